// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing front end for the 8-bit combinational alu with a 4x8 register file.
// Latency: instruction handshake at E0, ALU in EXEC, result/RF write at E1 (2 cycles), 1 instr per 3 cycles.
// Backpressure: res_ready low holds RESP (and instr_ready low) indefinitely; macro ALU_ISSUE_STICKY_OVF_EN enables ovf_sticky.
module alu_issue_ctrl #(
    parameter logic [7:0] RF_INIT = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_opcode,
    output logic [1:0]  alu_func,
    output logic        alu_en,
    input  logic [7:0]  alu_o,
    input  logic        alu_ovf,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_data,
    output logic        res_ovf,
    output logic        res_err,
    output logic [1:0]  res_rd,
    output logic        ovf_sticky,
    input  logic        clr_ovf
);

    localparam logic [2:0] OP_ARITH = 3'b000;
    localparam logic [2:0] OP_LOGIC = 3'b001;
    localparam logic [2:0] OP_LDI   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [7:0]  rf [4];
    logic [1:0]  rd_q;
    logic [7:0]  imm_q;

    // Decode of the latched instruction; only meaningful while in EXEC.
    logic is_arith;
    logic is_logic;
    logic is_ldi;
    assign is_arith = (alu_opcode == OP_ARITH) && !alu_func[1];
    assign is_logic = (alu_opcode == OP_LOGIC);
    assign is_ldi   = (alu_opcode == OP_LDI);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake/enable outputs; reset masks everything visible.
    always_comb begin
        next_state  = state;
        instr_ready = 1'b0;
        alu_en      = 1'b0;
        res_valid   = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                alu_en     = is_arith || is_logic;
                next_state = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (rst) begin
            instr_ready = 1'b0;
            alu_en      = 1'b0;
            res_valid   = 1'b0;
        end
    end

    // Operand fetch on acceptance, result capture and RF write-back leaving EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                rf[i] <= RF_INIT;
            end
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            alu_opcode <= 3'b000;
            alu_func   <= 2'b00;
            rd_q       <= 2'b00;
            imm_q      <= 8'h00;
            res_data   <= 8'h00;
            res_ovf    <= 1'b0;
            res_err    <= 1'b0;
            res_rd     <= 2'b00;
        end else begin
            if (state == IDLE && instr_valid) begin
                alu_opcode <= instr[15:13];
                alu_func   <= instr[12:11];
                rd_q       <= instr[10:9];
                alu_a      <= rf[instr[8:7]];
                alu_b      <= rf[instr[6:5]];
                imm_q      <= instr[7:0];
            end
            if (state == EXEC) begin
                res_rd <= rd_q;
                if (is_arith || is_logic) begin
                    res_data   <= alu_o;
                    res_ovf    <= alu_ovf;
                    res_err    <= 1'b0;
                    rf[rd_q]   <= alu_o;
                end else if (is_ldi) begin
                    res_data   <= imm_q;
                    res_ovf    <= 1'b0;
                    res_err    <= 1'b0;
                    rf[rd_q]   <= imm_q;
                end else begin
                    res_data   <= 8'h00;
                    res_ovf    <= 1'b0;
                    res_err    <= 1'b1;
                end
            end
        end
    end

`ifdef ALU_ISSUE_STICKY_OVF_EN
    // Sticky overflow: set by an overflowing add/sub, cleared by clr_ovf; set wins a tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (state == EXEC && is_arith && alu_ovf) begin
            ovf_sticky <= 1'b1;
        end else if (clr_ovf) begin
            ovf_sticky <= 1'b0;
        end
    end
`else
    logic unused_clr_ovf;
    assign unused_clr_ovf = clr_ovf;
    assign ovf_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural model of the combinational alu.
// Expected results are pushed to a scoreboard at issue time and popped on each result handshake.
// Honours ALU_ISSUE_STICKY_OVF_EN for the expected ovf_sticky value.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_opcode;
    logic [1:0]  alu_func;
    logic        alu_en;
    logic [7:0]  alu_o;
    logic        alu_ovf;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic        res_ovf;
    logic        res_err;
    logic [1:0]  res_rd;
    logic        ovf_sticky;
    logic        clr_ovf;

    typedef struct packed {
        logic [7:0] data;
        logic       ovf;
        logic       err;
        logic [1:0] rd;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] rf_m [4];
    logic       sticky_m;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] alu_sum;

    alu_issue_ctrl #(.RF_INIT(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_func    (alu_func),
        .alu_en      (alu_en),
        .alu_o       (alu_o),
        .alu_ovf     (alu_ovf),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_ovf     (res_ovf),
        .res_err     (res_err),
        .res_rd      (res_rd),
        .ovf_sticky  (ovf_sticky),
        .clr_ovf     (clr_ovf)
    );

    always #5 clk = ~clk;

    // Behavioural alu: outputs zero unless enabled.
    always_comb begin
        alu_sum = 9'h000;
        alu_o   = 8'h00;
        alu_ovf = 1'b0;
        if (alu_en) begin
            if (alu_opcode == 3'b000) begin
                if (alu_func[0]) alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
                else             alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
                alu_o   = alu_sum[7:0];
                alu_ovf = alu_sum[8];
            end else if (alu_opcode == 3'b001) begin
                case (alu_func)
                    2'b00:   alu_o = alu_a & alu_b;
                    2'b01:   alu_o = alu_a | alu_b;
                    2'b10:   alu_o = alu_a ^ alu_b;
                    default: alu_o = ~alu_a;
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard pop on every result handshake.
    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("res_data", {24'h0, res_data}, {24'h0, e.data});
                check("res_ovf",  {31'h0, res_ovf},  {31'h0, e.ovf});
                check("res_err",  {31'h0, res_err},  {31'h0, e.err});
                check("res_rd",   {30'h0, res_rd},   {30'h0, e.rd});
            end
        end
    end

    // Issue one instruction; hold>0 keeps res_ready low that many extra cycles
    // while offering a follow-up LDI (0xE655) that must not be accepted yet.
    task automatic issue(input logic [15:0] ins, input int hold);
        logic [2:0] op;
        logic [1:0] fn;
        logic [1:0] rd;
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] s;
        logic       en;
        exp_t       e;
        int         n;
        op = ins[15:13];
        fn = ins[12:11];
        rd = ins[10:9];
        a  = rf_m[ins[8:7]];
        b  = rf_m[ins[6:5]];
        en = 1'b0;
        e  = '{data: 8'h00, ovf: 1'b0, err: 1'b0, rd: rd};
        if (op == 3'b000 && fn[1] == 1'b0) begin
            en = 1'b1;
            s  = fn[0] ? ({1'b0, a} + {1'b0, ~b} + 9'd1) : ({1'b0, a} + {1'b0, b});
            e.data = s[7:0];
            e.ovf  = s[8];
`ifdef ALU_ISSUE_STICKY_OVF_EN
            if (s[8]) sticky_m = 1'b1;
`endif
            rf_m[rd] = s[7:0];
        end else if (op == 3'b001) begin
            en = 1'b1;
            case (fn)
                2'b00:   e.data = a & b;
                2'b01:   e.data = a | b;
                2'b10:   e.data = a ^ b;
                default: e.data = ~a;
            endcase
            rf_m[rd] = e.data;
        end else if (op == 3'b111) begin
            e.data   = ins[7:0];
            rf_m[rd] = ins[7:0];
        end else begin
            e.err = 1'b1;
        end
        sb_q.push_back(e);
        if (hold > 0) res_ready = 1'b0;

        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", n, 0);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 16'h0000;

        @(negedge clk);   // EXEC
        check("exec_alu_en", {31'h0, alu_en}, {31'h0, en});
        check("exec_res_valid", {31'h0, res_valid}, 32'd0);
        if (en) begin
            check("alu_a", {24'h0, alu_a}, {24'h0, a});
            check("alu_b", {24'h0, alu_b}, {24'h0, b});
        end
        @(negedge clk);   // RESP
        check("latency_res_valid", {31'h0, res_valid}, 32'd1);
        check("resp_alu_en", {31'h0, alu_en}, 32'd0);
        check("sticky", {31'h0, ovf_sticky}, {31'h0, sticky_m});

        if (hold > 0) begin
            instr       = 16'hE655;
            instr_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("stall_valid", {31'h0, res_valid}, 32'd1);
                check("stall_data", {24'h0, res_data}, {24'h0, e.data});
                check("stall_instr_ready", {31'h0, instr_ready}, 32'd0);
            end
            @(posedge clk);
            #1;
            res_ready = 1'b1;
            @(negedge clk);   // handshake cycle, scoreboard pops here
            check("hs_instr_ready", {31'h0, instr_ready}, 32'd0);
        end else begin
            n = 0;
            while (res_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("res_valid_drop", {31'h0, res_valid}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        res_ready   = 1'b1;
        clr_ovf     = 1'b0;
        sticky_m    = 1'b0;
        for (int i = 0; i < 4; i++) rf_m[i] = 8'h00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_instr_ready", {31'h0, instr_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_instr_ready", {31'h0, instr_ready}, 32'd1);
        check("reset_res_valid", {31'h0, res_valid}, 32'd0);
        check("reset_alu_en", {31'h0, alu_en}, 32'd0);
        check("reset_alu_a", {24'h0, alu_a}, 32'd0);
        check("reset_alu_b", {24'h0, alu_b}, 32'd0);
        check("reset_res_data", {24'h0, res_data}, 32'd0);
        check("reset_sticky", {31'h0, ovf_sticky}, 32'd0);

        issue(16'hE0F0, 0);   // LDI r0 = F0
        issue(16'hE220, 0);   // LDI r1 = 20
        issue(16'h0420, 0);   // ADD r2 = r0 + r1 -> 10, carry
        issue(16'h0E80, 0);   // SUB r3 = r1 - r0 -> 30
        issue(16'h3800, 0);   // NOT r0 -> 0F
        issue(16'h8000, 0);   // opcode 100: illegal
        issue(16'h1000, 0);   // ADD func 10: illegal
        issue(16'h0360, 0);   // r1 = r2 + r3 readback
        issue(16'h0420, 0);   // r2 = r0 + r1 readback

        // Clear sticky overflow.
        @(negedge clk);
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf  = 1'b0;
        sticky_m = 1'b0;
        @(negedge clk);
        check("clr_sticky", {31'h0, ovf_sticky}, 32'd0);

        issue(16'h0420, 5);   // stalled result
        issue(16'hE655, 0);   // offered during stall, accepted right after handshake
        issue(16'hE0FF, 0);   // LDI r0 = FF

        // Reset while a result is pending.
        res_ready = 1'b0;
        @(negedge clk);
        instr       = 16'h0000;   // ADD r0 = r0 + r0 -> carry
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pend_res_valid", {31'h0, res_valid}, 32'd1);
`ifdef ALU_ISSUE_STICKY_OVF_EN
        check("pend_sticky", {31'h0, ovf_sticky}, 32'd1);
`else
        check("pend_sticky", {31'h0, ovf_sticky}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) rf_m[i] = 8'h00;
        sticky_m = 1'b0;
        @(negedge clk);
        check("post_rst_res_valid", {31'h0, res_valid}, 32'd0);
        check("post_rst_instr_ready", {31'h0, instr_ready}, 32'd1);
        check("post_rst_sticky", {31'h0, ovf_sticky}, 32'd0);
        issue(16'h0020, 0);   // r0 = r0 + r1, both at init
        issue(16'h0160, 0);   // r0 = r2 + r3, both at init

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
